// File: rtl/mac_controller.sv
// Moore-style sequencer for a multiply-accumulate datapath: fetches N_TERMS operand
// pairs, steps each through load/multiply/accumulate, then publishes the sum.
module mac_controller #(
   parameter int N_TERMS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic [3:0] a_in,
   input  logic [3:0] b_in,
   output logic       in_ready,
   output logic [3:0] dp_a,
   output logic [3:0] dp_b,
   output logic       load_a,
   output logic       load_b,
   output logic       load_m,
   output logic       load_acc,
   output logic       load_out,
   output logic       count_enable,
   output logic       dp_clr,
   output logic       busy,
   output logic       done,
   output logic [3:0] term_cnt
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLR   = 3'd1;
   localparam logic [2:0] FETCH = 3'd2;
   localparam logic [2:0] LOAD  = 3'd3;
   localparam logic [2:0] MUL   = 3'd4;
   localparam logic [2:0] ACC   = 3'd5;
   localparam logic [2:0] OUT   = 3'd6;
   localparam logic [2:0] FIN   = 3'd7;

   localparam logic [3:0] LAST_TERM = 4'(N_TERMS - 1);

   logic [2:0] state_r;
   logic [2:0] next_state_s;

   // Next-state selection; start is only honoured from IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_state_s = CLR;
            else       next_state_s = IDLE;
         end
         CLR:  next_state_s = FETCH;
         FETCH: begin
            if (in_valid) next_state_s = LOAD;
            else          next_state_s = FETCH;
         end
         LOAD: next_state_s = MUL;
         MUL:  next_state_s = ACC;
         ACC: begin
            if (term_cnt == LAST_TERM) next_state_s = OUT;
            else                       next_state_s = FETCH;
         end
         OUT:  next_state_s = IDLE + 3'd7;
         FIN:  next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Strobes are flops loaded with the decode of the state being entered, so they
   // always equal the decode of the current state without any output glitching.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         in_ready     <= 1'b0;
         load_a       <= 1'b0;
         load_b       <= 1'b0;
         load_m       <= 1'b0;
         load_acc     <= 1'b0;
         load_out     <= 1'b0;
         count_enable <= 1'b0;
         dp_clr       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         in_ready     <= (next_state_s == FETCH);
         load_a       <= (next_state_s == LOAD);
         load_b       <= (next_state_s == LOAD);
         load_m       <= (next_state_s == MUL);
         load_acc     <= (next_state_s == ACC);
         load_out     <= (next_state_s == OUT);
         count_enable <= (next_state_s == ACC);
         dp_clr       <= (next_state_s == CLR);
         busy         <= (next_state_s != IDLE);
         done         <= (next_state_s == FIN);
      end
   end

   // Operand capture on the FETCH handshake and per-job term counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_a     <= 4'd0;
         dp_b     <= 4'd0;
         term_cnt <= 4'd0;
      end else begin
         if ((state_r == FETCH) && in_valid) begin
            dp_a <= a_in;
            dp_b <= b_in;
         end
         if ((state_r == IDLE) && start) begin
            term_cnt <= 4'd0;
         end else if (state_r == ACC) begin
            term_cnt <= term_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mac_controller.sv
// Self-checking bench for mac_controller: a timeline model predicts every output
// cycle by cycle, and a bench-side datapath confirms the accumulated sums.
module tb_mac_controller;

   logic       clk = 1'b0;
   logic       rst, start, start1, in_valid;
   logic [3:0] a_in, b_in;

   logic       in_ready, load_a, load_b, load_m, load_acc, load_out, count_enable, dp_clr, busy, done;
   logic [3:0] dp_a, dp_b, term_cnt;
   logic       in_ready1, load_a1, load_b1, load_m1, load_acc1, load_out1, count_enable1, dp_clr1, busy1, done1;
   logic [3:0] dp_a1, dp_b1, term_cnt1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mac_controller #(.N_TERMS(10)) u0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
      .in_ready(in_ready), .dp_a(dp_a), .dp_b(dp_b), .load_a(load_a), .load_b(load_b),
      .load_m(load_m), .load_acc(load_acc), .load_out(load_out), .count_enable(count_enable),
      .dp_clr(dp_clr), .busy(busy), .done(done), .term_cnt(term_cnt));

   mac_controller #(.N_TERMS(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
      .in_ready(in_ready1), .dp_a(dp_a1), .dp_b(dp_b1), .load_a(load_a1), .load_b(load_b1),
      .load_m(load_m1), .load_acc(load_acc1), .load_out(load_out1), .count_enable(count_enable1),
      .dp_clr(dp_clr1), .busy(busy1), .done(done1), .term_cnt(term_cnt1));

   // Behavioural datapaths: operand registers, product, accumulator, result.
   logic [3:0]  ra0, rb0, ra1, rb1;
   logic [7:0]  m0, m1;
   logic [11:0] acc0, acc1, out0, out1;

   always @(posedge clk) begin
      if (dp_clr) begin
         ra0 <= 4'd0; rb0 <= 4'd0; m0 <= 8'd0; acc0 <= 12'd0; out0 <= 12'd0;
      end else begin
         if (load_a)   ra0  <= dp_a;
         if (load_b)   rb0  <= dp_b;
         if (load_m)   m0   <= {4'd0, ra0} * {4'd0, rb0};
         if (load_acc) acc0 <= acc0 + {4'd0, m0};
         if (load_out) out0 <= acc0;
      end
      if (dp_clr1) begin
         ra1 <= 4'd0; rb1 <= 4'd0; m1 <= 8'd0; acc1 <= 12'd0; out1 <= 12'd0;
      end else begin
         if (load_a1)   ra1  <= dp_a1;
         if (load_b1)   rb1  <= dp_b1;
         if (load_m1)   m1   <= {4'd0, ra1} * {4'd0, rb1};
         if (load_acc1) acc1 <= acc1 + {4'd0, m1};
         if (load_out1) out1 <= acc1;
      end
   end

   typedef struct packed {
      logic       in_ready, load_ab, load_m, load_acc, load_out, count_en, dp_clr, busy, done;
      logic [3:0] dp_a, dp_b, term;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_q[$];
   exp_t idle_rec = '0;

   // Per-cycle comparison of u0 against the predicted timeline, plus strobe exclusivity.
   always @(negedge clk) begin
      exp_t e;
      exp_t a;
      if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
         e = exp_q.pop_front();
         void'(cyc_q.pop_front());
         if (e.done) begin
            idle_rec      = '0;
            idle_rec.dp_a = e.dp_a;
            idle_rec.dp_b = e.dp_b;
            idle_rec.term = e.term;
         end
      end else begin
         e = idle_rec;
      end
      a = {in_ready, load_a, load_m, load_acc, load_out, count_enable, dp_clr, busy, done,
           dp_a, dp_b, term_cnt};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h", cyc, a, e);
      end
      checks++;
      if ($countones({load_a, load_m, load_acc, load_out}) > 1 || load_a !== load_b ||
          $countones({load_a1, load_m1, load_acc1, load_out1}) > 1 || load_a1 !== load_b1) begin
         errors++;
         $display("FAIL strobe_exclusive cyc=%0d got u0=%b%b%b%b%b u1=%b%b%b%b%b expected at most one",
                  cyc, load_a, load_b, load_m, load_acc, load_out,
                  load_a1, load_b1, load_m1, load_acc1, load_out1);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pair(input logic [3:0] a0, input logic [3:0] b0,
                                       input bit vary, input int j);
      if (vary) return {4'(3 * j + 1), 4'(5 * j + 2)};
      else      return {a0, b0};
   endfunction

   task automatic push(input exp_t r, input int at);
      exp_q.push_back(r);
      cyc_q.push_back(at);
   endtask

   // One ten-term job on u0: builds the expected timeline, drives it, checks the result.
   task automatic job(input logic [3:0] a0, input logic [3:0] b0, input bit vary,
                      input int stall_term, input int stall_len,
                      input int sb1, input int sb2, input int sb3, input int rst_at,
                      input int exp_lat, input int exp_out, input int exp_dones);
      int c, o, len, first_done, dones, ces, st;
      int vcyc[10];
      exp_t r;
      logic [3:0] la, lb;
      logic [21:0] v;
      @(posedge clk); #2;
      c  = cyc;
      la = idle_rec.dp_a;
      lb = idle_rec.dp_b;
      r = '0; r.dp_clr = 1'b1; r.busy = 1'b1; r.dp_a = la; r.dp_b = lb; r.term = 4'd0;
      push(r, c + 1);
      o = 2;
      for (int j = 0; j < 10; j++) begin
         st = (j == stall_term) ? stall_len : 0;
         for (int s = 0; s <= st; s++) begin
            r = '0; r.in_ready = 1'b1; r.busy = 1'b1; r.dp_a = la; r.dp_b = lb; r.term = 4'(j);
            push(r, c + o); o++;
         end
         vcyc[j] = o - 1;
         {la, lb} = pair(a0, b0, vary, j);
         r = '0; r.load_ab = 1'b1; r.busy = 1'b1; r.dp_a = la; r.dp_b = lb; r.term = 4'(j);
         push(r, c + o); o++;
         r.load_ab = 1'b0; r.load_m = 1'b1;
         push(r, c + o); o++;
         r.load_m = 1'b0; r.load_acc = 1'b1; r.count_en = 1'b1;
         push(r, c + o); o++;
      end
      r = '0; r.load_out = 1'b1; r.busy = 1'b1; r.dp_a = la; r.dp_b = lb; r.term = 4'd10;
      push(r, c + o); o++;
      r.load_out = 1'b0; r.done = 1'b1;
      push(r, c + o);
      len = o;
      first_done = -1; dones = 0; ces = 0;
      for (o = 0; o <= len + 3; o++) begin
         if (o > 0) begin @(posedge clk); #2; end
         start    = (o == 0 || o == sb1 || o == sb2 || o == sb3);
         in_valid = 1'b1;
         a_in     = 4'($urandom);
         b_in     = 4'($urandom);
         for (int j = 0; j < 10; j++)
            if (o == vcyc[j]) {a_in, b_in} = pair(a0, b0, vary, j);
         if (stall_term >= 0 && o >= vcyc[stall_term] - stall_len && o < vcyc[stall_term])
            in_valid = 1'b0;
         if (o == rst_at) begin
            rst   = 1'b1;
            start = 1'b0;
            exp_q.delete();
            cyc_q.delete();
            idle_rec = '0;
            #1;
            v = {in_ready, load_a, load_b, load_m, load_acc, load_out, count_enable,
                 dp_clr, busy, done, dp_a, dp_b, term_cnt};
            checks++;
            if (v !== 22'd0) begin
               errors++;
               $display("FAIL reset_mid_job got=%h expected=000000", v);
            end
            break;
         end
         #1;
         if (done === 1'b1) begin
            dones++;
            if (first_done < 0) first_done = o;
         end
         if (count_enable === 1'b1) ces++;
      end
      start = 1'b0;
      if (rst === 1'b1) begin
         @(posedge clk); #2;
         rst = 1'b0;
      end
      chk("done_latency", first_done, exp_lat);
      chk("done_count", dones, exp_dones);
      if (exp_dones > 0) begin
         chk("final_sum", int'(out0), exp_out);
         chk("count_enable_pulses", ces, 10);
         chk("term_cnt_hold", int'(term_cnt), 10);
      end
   endtask

   initial begin
      int first_done, dones;
      logic [21:0] v;
      rst = 1'b1; start = 1'b0; start1 = 1'b0; in_valid = 1'b0; a_in = 4'd0; b_in = 4'd0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      v = {in_ready, load_a, load_b, load_m, load_acc, load_out, count_enable,
           dp_clr, busy, done, dp_a, dp_b, term_cnt};
      checks++;
      if (v !== 22'd0) begin
         errors++;
         $display("FAIL reset_state got=%h expected=000000", v);
      end

      job(4'd3,  4'd5,  1'b0, -1, 0, -1, -1, -1, -1, 43, 150,  1);
      job(4'd15, 4'd15, 1'b0,  3, 3, -1, -1, -1, -1, 46, 2250, 1);
      job(4'd2,  4'd4,  1'b0, -1, 0,  5, 42, 43, -1, 43, 80,   1);
      job(4'd4,  4'd4,  1'b0, -1, 0, -1, -1, -1, 24, -1, 0,    0);
      job(4'd1,  4'd2,  1'b0, -1, 0, -1, -1, -1, -1, 43, 20,   1);
      job(4'd0,  4'd0,  1'b1, -1, 0, -1, -1, -1, -1, 43, 502,  1);

      // Single-term instance: pair (7,9) with in_valid held high.
      first_done = -1; dones = 0;
      @(posedge clk); #2;
      for (int o = 0; o <= 12; o++) begin
         if (o > 0) begin @(posedge clk); #2; end
         start1   = (o == 0);
         in_valid = 1'b1;
         a_in     = 4'd7;
         b_in     = 4'd9;
         #1;
         if (done1 === 1'b1) begin
            dones++;
            if (first_done < 0) first_done = o;
         end
      end
      start1 = 1'b0;
      chk("n1_done_latency", first_done, 7);
      chk("n1_done_count", dones, 1);
      chk("n1_final_sum", int'(out1), 63);
      chk("n1_term_cnt", int'(term_cnt1), 1);
      chk("n1_busy_after", int'(busy1), 0);

      repeat (3) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
